// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmitter and the future receiver:
//   uartState_e   frame state machine states (IDLE/START/DATA/PARITY/STOP)
//   LINE_IDLE     level of the serial line between frames (mark = high)
//   MAX_DATA_BITS widest data field any UART in this codebase supports
//   calcParity    parity of a (zero-padded) data word, even or odd
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uartState_e;

  localparam logic LINE_IDLE     = 1'b1;
  localparam int   MAX_DATA_BITS = 9;

  // Unused upper bits must be zero so they do not disturb the XOR.
  // Odd parity is even parity inverted.
  function automatic logic calcParity(input logic [MAX_DATA_BITS-1:0] data,
                                      input logic                     odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
// Serial UART transmitter. Bytes arrive over a valid/ready handshake into a
// one-entry holding buffer and are sent as start bit, data bits (LSB first),
// optional parity bit and one or two stop bits. Bit timing comes entirely
// from the external baud_tick strobe. A byte buffered before the current
// frame ends follows it with no idle gap.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_i        synchronous active-low reset
//   baud_tick_i  one-cycle strobe, one bit period per tick interval
//   tx_data_i    byte to send, sampled only on accept
//   tx_valid_i   upstream has a byte
//   tx_ready_o   holding buffer empty (accept = tx_valid_i & tx_ready_o)
//   tx_o         registered serial line, idle high
//   tx_busy_o    a frame is on the line
//   tx_done_o    one-cycle pulse when the final stop bit completes
// ---------------------------------------------------------------------------
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 baud_tick_i,
  input  logic [DATA_BITS-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic                 tx_o,
  output logic                 tx_busy_o,
  output logic                 tx_done_o
);

  // One counter serves both the data field and the stop field.
  localparam int CNT_MAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);
  localparam logic             HAS_PAR   = (PARITY_EN != 0);
  localparam logic             ODD_PAR   = (PARITY_ODD != 0);

  uartState_e state_q, state_d;

  logic [DATA_BITS-1:0]     shift_q, shift_d;
  logic [DATA_BITS-1:0]     buf_q, buf_d;
  logic                     pending_q, pending_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     parity_q, parity_d;
  logic                     tx_q, tx_d;
  logic                     done_q, done_d;
  logic                     load;
  logic [MAX_DATA_BITS-1:0] bufPadded;

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and holding-buffer registers; reset also drops a buffered byte.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      shift_q   <= '0;
      buf_q     <= '0;
      pending_q <= 1'b0;
      cnt_q     <= '0;
      parity_q  <= 1'b0;
      tx_q      <= LINE_IDLE;
      done_q    <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      buf_q     <= buf_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic: every transition waits for a baud tick.
  always_comb begin
    state_d = state_q;
    if (baud_tick_i) begin
      case (state_q)
        IDLE:    if (pending_q) state_d = START;
        START:   state_d = DATA;
        DATA:    if (cnt_q == DATA_LAST) state_d = HAS_PAR ? PARITY : STOP;
        PARITY:  state_d = STOP;
        STOP:    if (cnt_q == STOP_LAST) state_d = pending_q ? START : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output and datapath logic. The line value for the next bit is computed
  // on the tick and registered, so tx_o changes one cycle after the tick.
  // A load happens on the tick that opens a start bit, either from IDLE or
  // straight out of the last stop bit for a gapless follow-on frame.
  always_comb begin
    tx_d     = tx_q;
    done_d   = 1'b0;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    parity_d = parity_q;
    load     = 1'b0;
    if (baud_tick_i) begin
      case (state_q)
        IDLE: begin
          tx_d = LINE_IDLE;
          if (pending_q) begin
            load = 1'b1;
            tx_d = ~LINE_IDLE;
          end
        end
        START: begin
          tx_d  = shift_q[0];
          cnt_d = '0;
        end
        DATA: begin
          if (cnt_q != DATA_LAST) begin
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            cnt_d   = cnt_q + CNT_W'(1);
          end else begin
            cnt_d = '0;
            tx_d  = HAS_PAR ? parity_q : LINE_IDLE;
          end
        end
        PARITY: begin
          tx_d  = LINE_IDLE;
          cnt_d = '0;
        end
        STOP: begin
          if (cnt_q != STOP_LAST) begin
            cnt_d = cnt_q + CNT_W'(1);
            tx_d  = LINE_IDLE;
          end else begin
            done_d = 1'b1;
            cnt_d  = '0;
            if (pending_q) begin
              load = 1'b1;
              tx_d = ~LINE_IDLE;
            end else begin
              tx_d = LINE_IDLE;
            end
          end
        end
        default: begin
          tx_d  = LINE_IDLE;
          cnt_d = '0;
        end
      endcase
    end
    // Parity is taken from the buffered word at load time, before shifting
    // destroys it.
    if (load) begin
      shift_d  = buf_q;
      parity_d = calcParity(bufPadded, ODD_PAR);
    end
  end

  // Zero-extend the buffered word to the width the parity helper expects.
  always_comb begin
    bufPadded                = '0;
    bufPadded[DATA_BITS-1:0] = buf_q;
  end

  // Holding buffer: accept only when empty, empty again on load. Accept and
  // load are mutually exclusive since one needs pending low, the other high.
  always_comb begin
    buf_d     = buf_q;
    pending_d = pending_q;
    if (load) begin
      pending_d = 1'b0;
    end else if (tx_valid_i && !pending_q) begin
      buf_d     = tx_data_i;
      pending_d = 1'b1;
    end
  end

  assign tx_o       = tx_q;
  assign tx_ready_o = !pending_q;
  assign tx_busy_o  = (state_q != IDLE);
  assign tx_done_o  = done_q;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter. Sits directly downstream of the baud-rate generator and consumes its one-cycle baud_tick strobe.
- Accepts parallel bytes over a valid/ready handshake through a one-entry holding buffer. Serialises each byte as start, data (LSB first), optional parity and stop bits.
- Frames go back-to-back with no idle gap when a new byte is buffered before the current frame ends.

Parameters:
- DATA_BITS, 8, data bits per frame (5..9).
- PARITY_EN, 0, 1 = append a parity bit after the data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-low reset.
- baud_tick  input  1  one-cycle strobe from the baud generator; each bit lasts exactly one tick-to-tick interval.
- tx_data  input  DATA_BITS  byte to send; sampled only on accept.
- tx_valid  input  1  upstream has a byte.
- tx_ready  output  1  holding buffer empty; accept = tx_valid & tx_ready.
- tx  output  1  serial line, registered, idle high.
- tx_busy  output  1  high while a frame is on the line.
- tx_done  output  1  one-cycle pulse when the final stop bit completes.

Behaviour:
- Reset (rst=0 at a clk edge) takes effect on that edge: tx=1, tx_ready=1, tx_busy=0, tx_done=0, FSM=IDLE, buffer empty, bit counter=0. This applies mid-frame: the line returns high on the next cycle and any buffered byte is discarded.
- Holding buffer:
  - tx_ready = !pending.
  - On accept, tx_data is latched and pending=1.
  - tx_valid while pending is ignored.
  - tx_data changes after accept have no effect.
- FSM states: IDLE, START, DATA, PARITY, STOP. State changes occur only on edges where baud_tick=1. tx is updated on the same edge, so it changes one cycle after the tick is seen.
- IDLE: tx=1. On baud_tick with pending=1:
  - load the shift register from the buffer;
  - clear pending;
  - go to START with tx=0.
- A byte accepted in the same cycle as a baud_tick does not start on that tick; it starts on the next tick. Start-bit latency from accept is therefore 1 to one full tick interval, plus 1 cycle.
- START: on tick -> DATA; tx = shift[0]; bit counter = 0.
- DATA: on tick:
  - if counter < DATA_BITS-1: shift right, tx = next bit, counter+1;
  - else go to PARITY (if PARITY_EN) or STOP, with tx = parity bit or 1.
- Parity bit = XOR of the data bits, inverted when PARITY_ODD=1.
- PARITY: on tick -> STOP; tx=1; counter=0.
- STOP: on tick:
  - if counter < STOP_BITS-1: counter+1, tx stays 1;
  - else (frame complete): tx_done=1 for that one cycle. If pending=1, go directly to START with tx=0 and load the buffer (gapless); else go to IDLE.
- tx_busy = 1 in START, DATA, PARITY and STOP; 0 in IDLE.
- baud_tick is ignored in IDLE when the buffer is empty.
- The counter width is $clog2(max(DATA_BITS, STOP_BITS)) and never wraps beyond its terminal value.

Decomposition:
- Shared package uart_pkg: FSM state enum (IDLE/START/DATA/PARITY/STOP), the line idle level constant, and a parity function, so the future uart_rx reuses them.
- No sub-module: the holding buffer and FSM stay in one module. The baud generator is instantiated by the parent, not inside this block.

Test Plan:
- Reset with tx_valid=1 held -> tx=1, tx_ready=1, tx_busy=0, tx_done=0; nothing accepted while rst=0.
- Default params, baud_tick every 4 cycles, send 0xA5 -> tx sequence per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1. tx_done pulses once, 40 cycles after the start bit begins.
- Send 0x3C then 0xFF with tx_valid held -> the second is accepted as soon as the first loads. Stop bit of frame 1 is followed immediately by the start bit of frame 2 (no idle bit). tx_ready is low from the second accept until frame 2 loads.
- PARITY_EN=1, PARITY_ODD=0, data 0x07 -> parity bit 1. With PARITY_ODD=1 -> parity bit 0. STOP_BITS=2 -> line high for 2 bit periods before tx_done.
- Accept coincident with baud_tick in IDLE -> start bit begins one cycle after the following tick, not the coincident one.
- Assert rst=0 for one cycle in the middle of the DATA state -> tx=1 next cycle, FSM idle, buffered byte dropped. A fresh byte afterwards is transmitted correctly.
